mmio_responder: RTL and testbench
=================================

// Module: mmio_responder
// PURPOSE
//   Memory-mapped I/O responder on the cpu data-memory port, placed in parallel with data_memory.
//   The cpu drives mem_wr_en/mem_op/mem_addr/mem_data_in. This block answers accesses inside its window:
//   - a test-status (tohost) register, so program-driven tests self-report pass/fail;
//   - a free-running cycle counter;
//   - a byte console drained through a valid/ready stream.
//   The top level selects mem_data_out from this block whenever hit=1.
// PARAMETERS
//   BASE_ADDR   32'h0000_8000  window base; window is 32 bytes, BASE_ADDR[4:0] must be 0
//   FIFO_DEPTH  8              console FIFO entries; power of two, >=2
// PORTS
//   clk          in   1   clock; all state updates on posedge
//   reset        in   1   synchronous, active-high reset
//   mem_wr_en    in   1   store strobe from cpu MEM stage
//   mem_op       in   mem_op_t  access size/sign (control_types)
//   mem_addr     in   32  byte address
//   mem_data_in  in   32  store data
//   mem_data_out out  32  load data, combinational; 0 when hit=0
//   hit          out  1   mem_addr[31:5]==BASE_ADDR[31:5]; combinational
//   tx_valid     out  1   console FIFO non-empty
//   tx_data      out  8   FIFO head byte; 0 when empty
//   tx_ready     in   1   sink accepts head when tx_valid&tx_ready
//   done         out  1   program wrote a result to TOHOST
//   pass         out  1   done and result==1
//   fail_code    out  31  result>>1 when done&!pass, else 0
// BEHAVIOUR
//   Register map (offset = mem_addr[4:0]):
//     0x00 TOHOST  RW
//     0x04 CYCLE   RW
//     0x08 TXDATA  W
//     0x0C TXSTAT  R
//     other offsets: reads return 0, writes are ignored
//   - Only word mem_op variants are honoured. A sub-word store in the window is ignored. A sub-word load returns the full word.
//   - Misaligned offsets (addr[1:0]!=0) read 0 and ignore writes.
//   - Loads are combinational, same cycle as mem_addr; no wait states.
//   - Stores commit on the posedge where mem_wr_en&hit.
//   Reset (posedge with reset=1):
//     - tohost=0, done=0, pass=0, fail_code=0, cycle=0
//     - FIFO empty, so tx_valid=0 and tx_data=0; overflow=0
//     - reset mid-operation discards all buffered bytes
//   TOHOST:
//     - The first store with data[0]=1 latches the value; done=1 on the next cycle.
//     - Once done=1, later TOHOST stores are ignored (result is sticky until reset).
//     - Stores with data[0]=0 update the readback value only.
//   CYCLE:
//     - Increments by 1 every non-reset cycle and wraps 32'hFFFF_FFFF->0.
//     - A store loads mem_data_in; the store takes priority over the increment that cycle. Next cycle the counter reads data+1.
//   TXDATA:
//     - A store pushes mem_data_in[7:0].
//     - When full with no pop in the same cycle, the byte is dropped and sticky overflow=1.
//     - When full and popped in the same cycle, push is accepted and count stays FULL.
//     - Empty FIFO: push and pop cannot coincide (tx_valid=0), so the push lands and tx_valid=1 next cycle.
//     - FIFO order is strictly FIFO. Pointers wrap modulo FIFO_DEPTH, with count width $clog2(FIFO_DEPTH)+1.
//   TXSTAT read fields:
//     {16'b0, count[7:0], 5'b0, overflow, full, empty}
//     - overflow clears only on reset.
//   tx_data holds stable while tx_valid&!tx_ready.
//   The block stays passive unless an access hits the window; stores outside the window have no effect here.
// STRUCTURE
//   Package mmio_pkg:
//     - offset localparams OFF_TOHOST, OFF_CYCLE, OFF_TXDATA, OFF_TXSTAT
//     - TXSTAT bit indices
//     - WINDOW_BITS=5
//   Sub-module mmio_tx_fifo (DEPTH, WIDTH=8):
//     - push/pop/full/empty/count
//     - synchronous active-high reset
//   Everything else stays in mmio_responder: address decode, tohost latch, counter, read mux.
// TESTING
//   1. Reset held 2 cycles then released:
//      - done=0, tx_valid=0
//      - CYCLE read 3 cycles after release = 3
//      - read of BASE+0x14 = 0
//   2. SW 32'h1 to TOHOST -> done=1 pass=1 next cycle. Later SW 32'h7 -> pass stays 1, TOHOST reads 1.
//      Separate run: SW 32'h7 first -> pass=0, fail_code=3.
//   3. SW 32'hFFFF_FFFE to CYCLE, then read on consecutive cycles -> FFFF_FFFF, then 0000_0000 (wrap).
//   4. tx_ready=0; push bytes 'A'..'I' (9 pushes, DEPTH=8):
//      - TXSTAT = count 8, full=1, overflow=1
//      - tx_ready=1 -> 'A'..'H' stream out in order, then tx_valid=0
//   5. FIFO full, tx_ready=1, push 'Z' in the same cycle as a pop:
//      - count stays 8, overflow unchanged
//      - 'Z' emerges last
//   6. Reset asserted mid-stream with 3 bytes queued -> next cycle tx_valid=0, count=0, overflow=0, done=0.
//      SH to TXDATA -> no push.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped I/O responder: access-size
// encoding, register offsets inside the 32-byte window and TXSTAT layout.
package mmio_pkg;

    // Access size/sign as driven by the cpu MEM stage
    typedef enum logic [2:0] {
        MEM_B  = 3'd0,
        MEM_H  = 3'd1,
        MEM_W  = 3'd2,
        MEM_BU = 3'd4,
        MEM_HU = 3'd5
    } mem_op_t;

    // Window is 2**WINDOW_BITS bytes
    localparam int WINDOW_BITS = 5;

    // Register offsets within the window
    localparam logic [WINDOW_BITS-1:0] OFF_TOHOST = 5'h00;
    localparam logic [WINDOW_BITS-1:0] OFF_CYCLE  = 5'h04;
    localparam logic [WINDOW_BITS-1:0] OFF_TXDATA = 5'h08;
    localparam logic [WINDOW_BITS-1:0] OFF_TXSTAT = 5'h0C;

    // TXSTAT bit positions
    localparam int TXSTAT_EMPTY_BIT    = 0;
    localparam int TXSTAT_FULL_BIT     = 1;
    localparam int TXSTAT_OVERFLOW_BIT = 2;
    localparam int TXSTAT_COUNT_LSB    = 8;
    localparam int TXSTAT_COUNT_W      = 8;

    // Only full-word accesses are honoured by the responder's stores
    function automatic logic is_word_op(input mem_op_t op);
        return op == MEM_W;
    endfunction

endpackage

// File: rtl/mmio_tx_fifo.sv
// Console byte FIFO: circular buffer with wrap-around pointers and an
// explicit occupancy count so full and empty are unambiguous.
module mmio_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic             pop_ok;
    logic             push_ok;

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign head_data = empty ? '0 : storage[rd_ptr];

    // Data storage needs no reset; validity is tracked by the count
    always_ff @(posedge clk) begin
        if (push_ok) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped I/O responder sitting beside data memory: a sticky test
// result register, a free-running cycle counter and a byte console stream.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_8000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_wr_en,
    input  mem_op_t     mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_data_out,
    output logic        hit,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_code
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [WINDOW_BITS-1:0] offset;
    logic                   aligned;
    logic                   wr_ok;
    logic                   wr_tohost;
    logic                   wr_cycle;
    logic                   wr_txdata;

    logic [31:0]            tohost_q;
    logic                   done_q;
    logic [31:0]            cycle_q;
    logic                   overflow_q;

    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic [31:0]            txstat;
    logic [31:0]            rd_data;

    // Address decode: window match, alignment and store qualification
    assign offset    = mem_addr[WINDOW_BITS-1:0];
    assign hit       = (mem_addr[31:WINDOW_BITS] == BASE_ADDR[31:WINDOW_BITS]);
    assign aligned   = (offset[1:0] == 2'b00);
    assign wr_ok     = mem_wr_en && hit && aligned && is_word_op(mem_op);
    assign wr_tohost = wr_ok && (offset == OFF_TOHOST);
    assign wr_cycle  = wr_ok && (offset == OFF_CYCLE);
    assign wr_txdata = wr_ok && (offset == OFF_TXDATA);

    // Test result: the first store with bit 0 set freezes the value until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            tohost_q <= '0;
            done_q   <= 1'b0;
        end else if (wr_tohost && !done_q) begin
            tohost_q <= mem_data_in;
            if (mem_data_in[0]) begin
                done_q <= 1'b1;
            end
        end
    end

    assign done      = done_q;
    assign pass      = done_q && (tohost_q == 32'd1);
    assign fail_code = (done_q && !pass) ? tohost_q[31:1] : '0;

    // Cycle counter: a store still counts its own cycle, so the value read
    // back on the following cycle is the stored data plus one
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
        end else if (wr_cycle) begin
            cycle_q <= mem_data_in + 32'd1;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    assign fifo_pop = tx_valid && tx_ready;

    mmio_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_txdata),
        .push_data (mem_data_in[7:0]),
        .pop       (fifo_pop),
        .head_data (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign tx_valid = !fifo_empty;

    // Overflow is sticky: set when a push finds the FIFO full with no pop to make room
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (wr_txdata && fifo_full && !fifo_pop) begin
            overflow_q <= 1'b1;
        end
    end

    // Assemble the console status word
    always_comb begin
        txstat = '0;
        txstat[TXSTAT_COUNT_LSB +: TXSTAT_COUNT_W] = TXSTAT_COUNT_W'(fifo_count);
        txstat[TXSTAT_OVERFLOW_BIT] = overflow_q;
        txstat[TXSTAT_FULL_BIT]     = fifo_full;
        txstat[TXSTAT_EMPTY_BIT]    = fifo_empty;
    end

    // Load mux: combinational, full word regardless of access size
    always_comb begin
        rd_data = '0;
        if (hit && aligned) begin
            case (offset)
                OFF_TOHOST: rd_data = tohost_q;
                OFF_CYCLE:  rd_data = cycle_q;
                OFF_TXSTAT: rd_data = txstat;
                default:    rd_data = '0;
            endcase
        end
    end

    assign mem_data_out = rd_data;

endmodule

// File: tb/tb_mmio_responder.sv
// Randomized scoreboard bench for mmio_responder with a queue-based
// behavioural reference model.
module tb_mmio_responder;
    import mmio_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_8000;
    localparam int          DEPTH = 8;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_wr_en = 1'b0;
    mem_op_t     mem_op = MEM_W;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_data_in = 32'h0;
    logic [31:0] mem_data_out;
    logic        hit;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        done;
    logic        pass;
    logic [30:0] fail_code;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;
    bit rd_req = 1'b0;
    exp_t exp_q[$];
    logic [7:0] rx_log[$];

    // reference model state
    logic [31:0] m_cycle = 32'h0;
    logic [31:0] m_tohost = 32'h0;
    bit          m_done = 1'b0;
    bit          m_over = 1'b0;
    logic [7:0]  m_fifo[$];

    mmio_responder #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_wr_en    (mem_wr_en),
        .mem_op       (mem_op),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .hit          (hit),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .done         (done),
        .pass         (pass),
        .fail_code    (fail_code)
    );

    always #5 clk = ~clk;

    function automatic bit in_window(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd32);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (in_window(a) && (a % 4 == 0)) begin
            case (a - BASE)
                32'h0: r = m_tohost;
                32'h4: r = m_cycle;
                32'hC: r = (m_fifo.size() * 256) + (m_over ? 4 : 0)
                         + ((m_fifo.size() == DEPTH) ? 2 : 0)
                         + ((m_fifo.size() == 0) ? 1 : 0);
                default: r = 32'h0;
            endcase
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic wr, input mem_op_t op,
                                 input logic [31:0] addr, input logic [31:0] data, input logic rdy);
        @(posedge clk);
        #1;
        reset       = rst;
        mem_wr_en   = wr;
        mem_op      = op;
        mem_addr    = addr;
        mem_data_in = data;
        tx_ready    = rdy;
        rd_req      = 1'b0;
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 1'b0, MEM_W, 32'h0000_0100, 32'h0, rdy);
    endtask

    task automatic store(input logic [31:0] off, input logic [31:0] data, input mem_op_t op, input logic rdy);
        applyStimulus(1'b0, 1'b1, op, BASE + off, data, rdy);
    endtask

    task automatic readModel(input logic [31:0] addr, input mem_op_t op, input logic rdy, input string name);
        exp_t e;
        applyStimulus(1'b0, 1'b0, op, addr, 32'h0, rdy);
        e.name = name;
        e.value = model_read(addr);
        exp_q.push_back(e);
        rd_req = 1'b1;
    endtask

    task automatic readExpect(input logic [31:0] addr, input logic rdy, input string name, input logic [31:0] value);
        exp_t e;
        applyStimulus(1'b0, 1'b0, MEM_W, addr, 32'h0, rdy);
        e.name = name;
        e.value = value;
        exp_q.push_back(e);
        rd_req = 1'b1;
    endtask

    // Reference model: advances once per clock from the inputs held during that cycle
    initial begin
        bit st;
        bit pop_now;
        logic [31:0] off;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_cycle = 32'h0;
                m_tohost = 32'h0;
                m_done = 1'b0;
                m_over = 1'b0;
                m_fifo.delete();
            end else begin
                off = mem_addr - BASE;
                st = mem_wr_en && in_window(mem_addr) && (mem_addr % 4 == 0) && (mem_op == MEM_W);
                pop_now = (m_fifo.size() > 0) && tx_ready;
                if (st && off == 32'h4) m_cycle = mem_data_in + 32'd1;
                else m_cycle = m_cycle + 32'd1;
                if (st && off == 32'h0 && !m_done) begin
                    m_tohost = mem_data_in;
                    if (mem_data_in[0]) m_done = 1'b1;
                end
                if (pop_now) void'(m_fifo.pop_front());
                if (st && off == 32'h8) begin
                    if (m_fifo.size() < DEPTH) m_fifo.push_back(mem_data_in[7:0]);
                    else m_over = 1'b1;
                end
            end
        end
    end

    // Monitor: compares outputs against the model and the read scoreboard mid-cycle
    initial begin
        exp_t e;
        bit exp_pass;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_pass = m_done && (m_tohost == 32'd1);
                checkOutput("hit", 32'(hit), 32'(in_window(mem_addr)));
                checkOutput("done", 32'(done), 32'(m_done));
                checkOutput("pass", 32'(pass), 32'(exp_pass));
                checkOutput("fail_code", 32'(fail_code), (m_done && !exp_pass) ? (m_tohost >> 1) : 32'h0);
                checkOutput("tx_valid", 32'(tx_valid), 32'(m_fifo.size() != 0));
                checkOutput("tx_data", 32'(tx_data), (m_fifo.size() != 0) ? 32'(m_fifo[0]) : 32'h0);
                if (tx_valid && tx_ready) rx_log.push_back(tx_data);
                if (rd_req) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL read_scoreboard actual=empty expected=entry");
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput(e.name, mem_data_out, e.value);
                    end
                end
            end
        end
    end

    // Directed scenarios followed by a randomized phase
    initial begin
        logic [31:0] offs [10];
        mem_op_t ops [5];
        offs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h1C, 32'h1, 32'h6, 32'hA};
        ops  = '{MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU};

        // reset held two cycles, then released
        applyStimulus(1'b1, 1'b0, MEM_W, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, MEM_W, 32'h0, 32'h0, 1'b0);
        mon_en = 1'b1;
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        readExpect(BASE + 32'h4, 1'b0, "cycle_after_reset", 32'd3);
        readExpect(BASE + 32'h14, 1'b0, "unmapped_0x14", 32'h0);

        // passing result is sticky
        store(32'h0, 32'h1, MEM_W, 1'b0);
        idle(1'b0);
        @(negedge clk);
        checkOutput("pass_after_sw1", 32'(pass), 32'd1);
        store(32'h0, 32'h7, MEM_W, 1'b0);
        readExpect(BASE, 1'b0, "tohost_sticky", 32'h1);

        // failing result
        applyStimulus(1'b1, 1'b0, MEM_W, 32'h0, 32'h0, 1'b0);
        store(32'h0, 32'h7, MEM_W, 1'b0);
        idle(1'b0);
        @(negedge clk);
        checkOutput("fail_code_7", 32'(fail_code), 32'd3);
        checkOutput("pass_7", 32'(pass), 32'd0);

        // cycle counter wrap
        store(32'h4, 32'hFFFF_FFFE, MEM_W, 1'b0);
        readExpect(BASE + 32'h4, 1'b0, "cycle_pre_wrap", 32'hFFFF_FFFF);
        readExpect(BASE + 32'h4, 1'b0, "cycle_wrap", 32'h0);

        // overflow: nine pushes into eight slots
        for (int i = 0; i < 9; i++) store(32'h8, 32'h41 + i, MEM_W, 1'b0);
        readExpect(BASE + 32'hC, 1'b0, "txstat_overflow", 32'h0000_0806);
        rx_log.delete();
        for (int i = 0; i < 11; i++) idle(1'b1);
        checkOutput("rx_count_AH", rx_log.size(), 8);
        for (int i = 0; i < 8 && i < rx_log.size(); i++)
            checkOutput($sformatf("rx_byte_%0d", i), 32'(rx_log[i]), 32'h41 + i);

        // simultaneous push and pop while full
        applyStimulus(1'b1, 1'b0, MEM_W, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) store(32'h8, 32'h30 + i, MEM_W, 1'b0);
        store(32'h8, 32'h5A, MEM_W, 1'b1);
        readExpect(BASE + 32'hC, 1'b0, "txstat_full_pushpop", 32'h0000_0802);
        rx_log.delete();
        for (int i = 0; i < 11; i++) idle(1'b1);
        checkOutput("rx_count_Z", rx_log.size(), 8);
        if (rx_log.size() == 8) begin
            checkOutput("rx_first_Z", 32'(rx_log[0]), 32'h31);
            checkOutput("rx_last_Z", 32'(rx_log[7]), 32'h5A);
        end

        // reset mid-stream discards buffered bytes
        store(32'h0, 32'h1, MEM_W, 1'b0);
        for (int i = 0; i < 3; i++) store(32'h8, 32'h61 + i, MEM_W, 1'b0);
        applyStimulus(1'b1, 1'b0, MEM_W, 32'h0, 32'h0, 1'b0);
        readExpect(BASE + 32'hC, 1'b0, "txstat_after_reset", 32'h0000_0001);
        store(32'h8, 32'h66, MEM_H, 1'b0);
        readExpect(BASE + 32'hC, 1'b0, "txstat_after_sh", 32'h0000_0001);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            mem_op_t op;
            logic rdy;
            int sel;
            sel = int'($urandom_range(0, 11));
            if (sel < 10) a = BASE + offs[sel];
            else if (sel == 10) a = BASE + 32'd32;
            else a = BASE - 32'd4;
            op = ($urandom_range(0, 3) == 0) ? ops[$urandom_range(0, 4)] : MEM_W;
            rdy = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 79) == 0)
                applyStimulus(1'b1, 1'b0, MEM_W, 32'h0, 32'h0, rdy);
            else if ($urandom_range(0, 1) == 1)
                applyStimulus(1'b0, 1'b1, op, a, $urandom, rdy);
            else
                readModel(a, op, rdy, $sformatf("rand_read_%h", a));
        end
        idle(1'b0);
        idle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
